// File: rtl/home_auto_pkg.sv
// Shared definitions for the home-automation controller: contact indices, temperature
// width and the heater/cooler thresholds used by the controller FSM.
package home_auto_pkg;

  localparam int SENS_FD = 0;  // front door
  localparam int SENS_RD = 1;  // rear door
  localparam int SENS_FA = 2;  // fire alarm
  localparam int SENS_W  = 3;  // window
  localparam int N_SENS  = 4;

  localparam int TEMP_W = 6;

  localparam int TEMP_HEAT_BELOW = 10;
  localparam int TEMP_COOL_ABOVE = 21;

  // The fire contact gets its own (shorter) debounce so alarm latency stays small.
  function automatic int debounce_len(int idx, int n_contact, int n_fire);
    return (idx == SENS_FA) ? n_fire : n_contact;
  endfunction

endpackage

// File: rtl/home_debounce_bit.sv
// One contact channel: 2-flop synchronizer, consecutive-mismatch counter and the
// debounced stable bit. 'changed' flags that stable flips at the coming edge.
module home_debounce_bit #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  assign changed = (s2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge value of the others; blocking here would collapse s1/s2 into one stage.
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/home_sensor_conditioner.sv
// Front end for the home-automation FSM: debounces the four contacts and produces a
// 4-sample moving average of the temperature, sampled every SAMPLE_DIV cycles.
module home_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int FIRE_DEBOUNCE   = 2,
  parameter int CNT_W           = 4,
  parameter int TEMP_W          = home_auto_pkg::TEMP_W,
  parameter int AVG_LOG2        = 2,
  parameter int SAMPLE_DIV      = 16,
  parameter int TEMP_RESET      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        sensors_raw,
  input  logic [TEMP_W-1:0] temp_raw,
  output logic [3:0]        sensors,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_valid,
  output logic              sensor_change
);

  import home_auto_pkg::*;

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = TEMP_W + AVG_LOG2;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int FILL_W = AVG_LOG2 + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  // ---------------------------------------------------------------- contacts
  logic [N_SENS-1:0] bit_changed;

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    home_debounce_bit #(
      .N     (debounce_len(i, DEBOUNCE_CYCLES, FIRE_DEBOUNCE)),
      .CNT_W (CNT_W)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw     (sensors_raw[i]),
      .stable  (sensors[i]),
      .changed (bit_changed[i])
    );
  end

  // Simultaneous flips on several channels merge into one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sensor_change <= 1'b0;
    end else begin
      sensor_change <= |bit_changed;
    end
  end

  // ------------------------------------------------------------- temperature
  logic [DIV_W-1:0]  div;
  logic              strobe;
  logic [TEMP_W-1:0] window [DEPTH];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  next_sum;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] next_fill;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here unconditionally);
    // a path that skips an assignment would infer a latch.
    strobe    = (div == DIV_LAST);
    next_sum  = sum + SUM_W'(temp_raw) - SUM_W'(window[DEPTH-1]);
    next_fill = (fill == FILL_FULL) ? fill : fill + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      sum        <= '0;
      fill       <= '0;
      temp       <= TEMP_W'(TEMP_RESET);
      temp_valid <= 1'b0;
      // NOTE: the window is small register storage, not RAM, and must be cleared:
      // the running sum subtracts the oldest entry, so stale data would corrupt it.
      for (int i = 0; i < DEPTH; i++) begin
        window[i] <= '0;
      end
    end else begin
      div <= strobe ? '0 : div + 1'b1;
      if (strobe) begin
        window[0] <= temp_raw;
        for (int i = 1; i < DEPTH; i++) begin
          window[i] <= window[i-1];
        end
        sum  <= next_sum;
        fill <= next_fill;
        if (next_fill == FILL_FULL) begin
          temp       <= TEMP_W'(next_sum >> AVG_LOG2);
          temp_valid <= 1'b1;
        end
      end
    end
  end

  // Invariants the controller FSM relies on.
  a_valid_sticky : assert property (@(posedge clk) disable iff (rst)
    temp_valid |=> temp_valid);
  a_reset_temp   : assert property (@(posedge clk) disable iff (rst)
    !temp_valid |-> (temp == TEMP_W'(TEMP_RESET)));

endmodule

// File: tb/tb_home_sensor_conditioner.sv
// Self-checking bench: directed scenarios plus randomized stimulus, every cycle compared
// against a behavioural model (sample history windows and a plain moving average).
module tb_home_sensor_conditioner;
  import home_auto_pkg::*;

  localparam int DEB    = 8;
  localparam int FIRE   = 2;
  localparam int DEPTH  = 4;
  localparam int SDIV   = 16;
  localparam int TRESET = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        sensors_raw;
  logic [TEMP_W-1:0] temp_raw;
  logic [3:0]        sensors;
  logic [TEMP_W-1:0] temp;
  logic              temp_valid;
  logic              sensor_change;

  always #5 clk = ~clk;

  home_sensor_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .FIRE_DEBOUNCE   (FIRE),
    .CNT_W           (4),
    .TEMP_W          (TEMP_W),
    .AVG_LOG2        (2),
    .SAMPLE_DIV      (SDIV),
    .TEMP_RESET      (TRESET)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensors_raw   (sensors_raw),
    .temp_raw      (temp_raw),
    .sensors       (sensors),
    .temp          (temp),
    .temp_valid    (temp_valid),
    .sensor_change (sensor_change)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [3:0] raw_hist[$];   // last two sampled raw vectors (synchronizer delay)
  logic [3:0] seen_hist[$];  // synchronized values seen by the debouncer, newest last
  logic [3:0] m_sensors;
  logic       m_change;
  int         m_edges;
  int         samples[$];
  int         m_temp;
  logic       m_valid;

  task automatic model_reset();
    raw_hist.delete();
    raw_hist.push_back(4'h0);
    raw_hist.push_back(4'h0);
    seen_hist.delete();
    m_sensors = 4'h0;
    m_change  = 1'b0;
    m_edges   = 0;
    samples.delete();
    m_temp    = TRESET;
    m_valid   = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic [TEMP_W-1:0] t);
    logic [3:0] nxt;
    int         n;
    bit         all_diff;
    int         total;
    seen_hist.push_back(raw_hist[0]);
    if (seen_hist.size() > DEB) void'(seen_hist.pop_front());
    raw_hist.push_back(raw);
    void'(raw_hist.pop_front());
    // A bit flips once its last N synchronized samples all disagree with it.
    nxt = m_sensors;
    for (int b = 0; b < 4; b++) begin
      n = (b == SENS_FA) ? FIRE : DEB;
      if (seen_hist.size() >= n) begin
        all_diff = 1'b1;
        for (int j = 0; j < n; j++)
          if (seen_hist[seen_hist.size()-1-j][b] == m_sensors[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~m_sensors[b];
      end
    end
    m_change  = (nxt != m_sensors);
    m_sensors = nxt;
    // Temperature: a sample every SDIV edges, average of the last DEPTH samples.
    m_edges++;
    if (m_edges % SDIV == 0) begin
      samples.push_back(int'(t));
      if (samples.size() > DEPTH) void'(samples.pop_front());
      if (samples.size() == DEPTH) begin
        total = 0;
        foreach (samples[i]) total += samples[i];
        m_temp  = total / DEPTH;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic [TEMP_W-1:0] t);
    rst         = r;
    sensors_raw = s;
    temp_raw    = t;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(s, t);
    #1;
    check("sensors",       32'(sensors),       32'(m_sensors));
    check("temp",          32'(temp),          32'(m_temp));
    check("temp_valid",    32'(temp_valid),    32'(m_valid));
    check("sensor_change", 32'(sensor_change), 32'(m_change));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sensors"}, 32'(sensors),       0);
    check({tag, "_temp"},    32'(temp),          TRESET);
    check({tag, "_valid"},   32'(temp_valid),    0);
    check({tag, "_change"},  32'(sensor_change), 0);
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    int         exp_down[4];
    int         hold;
    logic [3:0] s;
    logic       r;
    logic       tog;
    exp_down = '{47, 31, 15, 0};

    // Reset with random inputs, then the temperature path.
    step(1'b1, 4'($urandom()), TEMP_W'($urandom()));
    step(1'b1, 4'($urandom()), TEMP_W'($urandom()));
    check_reset_state("rst");

    for (int e = 1; e <= 64; e++) begin
      step(1'b0, 4'h0, TEMP_W'(8));
      if (e == 63) begin
        check("fill63_temp",  32'(temp),       TRESET);
        check("fill63_valid", 32'(temp_valid), 0);
      end
      if (e == 64) begin
        check("fill64_temp",  32'(temp),       8);
        check("fill64_valid", 32'(temp_valid), 1);
      end
    end
    for (int e = 1; e <= 64; e++) begin
      step(1'b0, 4'h0, TEMP_W'(24));
      if (e % 16 == 0) check("ramp_up", 32'(temp), 32'(8 + 4 * (e / 16)));
    end
    for (int e = 1; e <= 64; e++) step(1'b0, 4'h0, TEMP_W'(63));
    check("max_no_wrap", 32'(temp), 63);
    for (int e = 1; e <= 64; e++) begin
      step(1'b0, 4'h0, TEMP_W'(0));
      if (e % 16 == 0) check("ramp_down", 32'(temp), 32'(exp_down[e/16-1]));
    end

    // Debounce: bouncing front door never settles.
    step(1'b1, 4'h0, TEMP_W'(8));
    for (int c = 0; c < 30; c++) begin
      tog = ((c / 3) % 2 == 0);
      step(1'b0, {3'b000, tog}, TEMP_W'(8));
      check("bounce_sens0",  32'(sensors[0]),    0);
      check("bounce_change", 32'(sensor_change), 0);
    end
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 4'b0001, TEMP_W'(8));
      check("door_latency", 32'(sensors[0]),    32'(j >= 9));
      check("door_pulse",   32'(sensor_change), 32'(j == 9));
    end
    // Fire and window raised together: two separate pulses.
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 4'b1101, TEMP_W'(8));
      check("fire_latency",   32'(sensors[2]),    32'(j >= 3));
      check("window_latency", 32'(sensors[3]),    32'(j >= 9));
      check("fire_win_pulse", 32'(sensor_change), 32'(j == 3 || j == 9));
    end
    // Door and window drop together: single merged pulse.
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 4'b0100, TEMP_W'(8));
      check("merge_sensors", 32'(sensors),       (j >= 9) ? 32'h4 : 32'hd);
      check("merge_pulse",   32'(sensor_change), 32'(j == 9));
    end

    // Reset mid-debounce (cnt=5) and mid-fill (fill=2) discards progress.
    step(1'b1, 4'h0, TEMP_W'(0));
    for (int e = 1; e <= 32; e++) step(1'b0, (e >= 26) ? 4'b0001 : 4'b0000, TEMP_W'(40));
    check("middeb_sens0", 32'(sensors[0]), 0);
    step(1'b1, 4'b0001, TEMP_W'(40));
    check_reset_state("midrst");
    for (int e = 1; e <= 64; e++) begin
      step(1'b0, 4'b0001, TEMP_W'(40));
      check("rerun_sens0", 32'(sensors[0]), 32'(e >= 10));
      if (e >= 63) begin
        check("rerun_valid", 32'(temp_valid), 32'(e >= 64));
        check("rerun_temp",  32'(temp),       (e >= 64) ? 32'd40 : 32'(TRESET));
      end
    end

    // Randomized: held contact patterns, noisy temperature, rare resets.
    hold = 0;
    s    = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        s    = 4'($urandom());
        hold = $urandom_range(1, 12);
      end
      hold--;
      r = ($urandom_range(0, 499) == 0);
      step(r, s, TEMP_W'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
